// File: rtl/retry_replay_arbiter.sv
// retry_replay_arbiter: round-robin scheduler that moves replay requests from
// the per-slot retry counters onto the single replay-buffer read port. One
// replay is in flight at a time. A replay that is accepted but never finishes
// raises a sticky error, and the arbiter stops granting until reset.
module retry_replay_arbiter #(
    parameter int RETRY_TLP_SIZE = 3,
    parameter int DONE_TIMEOUT   = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [RETRY_TLP_SIZE-1:0] retry_valid_i,
    output logic [RETRY_TLP_SIZE-1:0] retry_ack_o,
    output logic [RETRY_TLP_SIZE-1:0] retry_complete_o,
    input  logic                      tx_busy_i,
    output logic                      replay_req_o,
    output logic [7:0]                replay_index_o,
    input  logic                      replay_ack_i,
    input  logic                      replay_done_i,
    output logic                      replay_busy_o,
    output logic                      replay_err_o,
    output logic [CNT_WIDTH-1:0]      replay_count_o
);

    localparam int PTR_W = (RETRY_TLP_SIZE > 1) ? $clog2(RETRY_TLP_SIZE) : 1;
    localparam int TMR_W = $clog2(DONE_TIMEOUT) + 1;

    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(RETRY_TLP_SIZE - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(DONE_TIMEOUT - 1);
    localparam logic [PTR_W:0]   SLOT_CNT  = (PTR_W + 1)'(RETRY_TLP_SIZE);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_ERR    = 2'd3;

    logic [1:0]                state_q,     state_d;
    logic [PTR_W-1:0]          rr_ptr_q,    rr_ptr_d;
    logic [PTR_W-1:0]          grant_idx_q, grant_idx_d;
    logic [TMR_W-1:0]          timer_q,     timer_d;
    logic [CNT_WIDTH-1:0]      count_q,     count_d;
    logic                      err_q,       err_d;
    logic [RETRY_TLP_SIZE-1:0] ack_q,       ack_d;
    logic [RETRY_TLP_SIZE-1:0] cmp_q,       cmp_d;

    logic                      pick_found;
    logic [PTR_W-1:0]          pick_idx;
    logic [PTR_W:0]            cand;
    logic [RETRY_TLP_SIZE-1:0] grant_onehot;

    // Round-robin pick: first requesting slot at or above rr_ptr, wrapping.
    always_comb begin
        // NOTE: every variable driven here is given a default first, so no
        // path through the block can leave it holding a value (no latch).
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < RETRY_TLP_SIZE; k++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
            if (cand >= SLOT_CNT) begin
                cand = cand - SLOT_CNT;
            end
            if (!pick_found && retry_valid_i[cand[PTR_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // One-hot form of the current winner, used for the per-slot pulses.
    always_comb begin
        grant_onehot              = '0;
        grant_onehot[grant_idx_q] = 1'b1;
    end

    // Next-state logic for the grant / stream / timeout sequence.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        timer_d     = timer_q;
        count_d     = count_q;
        err_d       = err_q;
        ack_d       = '0;
        cmp_d       = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found && !tx_busy_i) begin
                    grant_idx_d = pick_idx;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // An ack in the same cycle as a withdrawal still counts.
                if (replay_ack_i) begin
                    ack_d   = grant_onehot;
                    timer_d = '0;
                    state_d = ST_STREAM;
                end else if (!retry_valid_i[grant_idx_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                // Done on the expiry cycle is still a completion.
                if (replay_done_i) begin
                    cmp_d    = grant_onehot;
                    rr_ptr_d = (grant_idx_q == LAST_SLOT) ? '0 : grant_idx_q + 1'b1;
                    if (count_q != '1) begin
                        count_d = count_q + 1'b1;
                    end
                    state_d = ST_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                // Terminal: only reset leaves the error state.
                err_d   = 1'b1;
                state_d = ST_ERR;
            end
        endcase
    end

    // State registers; reset clears everything, abandoning any replay.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: non-blocking assignments, so every register samples the
        // pre-edge values regardless of statement order.
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            timer_q     <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            ack_q       <= '0;
            cmp_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            timer_q     <= timer_d;
            count_q     <= count_d;
            err_q       <= err_d;
            ack_q       <= ack_d;
            cmp_q       <= cmp_d;
        end
    end

    assign replay_req_o     = (state_q == ST_GRANT);
    assign replay_busy_o    = (state_q != ST_IDLE);
    assign replay_index_o   = 8'(grant_idx_q);
    assign replay_err_o     = err_q;
    assign replay_count_o   = count_q;
    assign retry_ack_o      = ack_q;
    assign retry_complete_o = cmp_q;

endmodule

// File: tb/tb_retry_replay_arbiter.sv
// Bench for retry_replay_arbiter: a fixed vector table, hand-written corner
// sequences, then random traffic against a transaction-level reference model.
module tb_retry_replay_arbiter;

    localparam int N   = 3;
    localparam int TO  = 8;
    localparam int CW  = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  valid = '0;
    logic          tx_busy = 1'b0;
    logic          rack = 1'b0;
    logic          rdone = 1'b0;

    logic [N-1:0]  ack_o, cmp_o;
    logic          req_o, busy_o, err_o;
    logic [7:0]    idx_o;
    logic [CW-1:0] cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    retry_replay_arbiter #(
        .RETRY_TLP_SIZE(N),
        .DONE_TIMEOUT  (TO),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .retry_valid_i   (valid),
        .retry_ack_o     (ack_o),
        .retry_complete_o(cmp_o),
        .tx_busy_i       (tx_busy),
        .replay_req_o    (req_o),
        .replay_index_o  (idx_o),
        .replay_ack_i    (rack),
        .replay_done_i   (rdone),
        .replay_busy_o   (busy_o),
        .replay_err_o    (err_o),
        .replay_count_o  (cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: tracks which slot owns the buffer and how the replay
    // has progressed, rather than any particular state encoding.
    int           m_owner;     // -1 when no slot holds the buffer
    bit           m_accepted;  // buffer has taken the owner's request
    int           m_age;       // streaming cycles elapsed since acceptance
    bit           m_dead;      // buffer stalled: no more service
    int           m_ptr;       // slot with first claim on the next grant
    int           m_cnt;
    logic [N-1:0] m_ack, m_cmp;

    task automatic model_reset();
        m_owner = -1; m_accepted = 0; m_age = 0; m_dead = 0;
        m_ptr = 0; m_cnt = 0; m_ack = '0; m_cmp = '0;
    endtask

    task automatic model_step();
        m_ack = '0;
        m_cmp = '0;
        if (!rst_n) begin
            model_reset();
        end else if (m_dead) begin
            // nothing happens after a stall
        end else if (m_owner < 0) begin
            if (valid != '0 && !tx_busy) begin
                for (int k = 0; k < N; k++) begin
                    if (valid[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        break;
                    end
                end
            end
        end else if (!m_accepted) begin
            if (rack) begin
                m_accepted = 1;
                m_age = 0;
                m_ack[m_owner] = 1'b1;
            end else if (!valid[m_owner]) begin
                m_owner = -1;
            end
        end else begin
            if (rdone) begin
                m_cmp[m_owner] = 1'b1;
                m_ptr = (m_owner + 1) % N;
                m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
                m_owner = -1;
                m_accepted = 0;
            end else begin
                m_age++;
                if (m_age >= TO) m_dead = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; valid = '0; tx_busy = 1'b0; rack = 1'b0; rdone = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_model(input string tag);
        bit exp_req;
        exp_req = (m_owner >= 0) && !m_accepted && !m_dead;
        check({tag, "_req"}, req_o, exp_req);
        if (exp_req) check({tag, "_idx"}, idx_o, m_owner);
        check({tag, "_ack"}, ack_o, m_ack);
        check({tag, "_cmp"}, cmp_o, m_cmp);
        check({tag, "_busy"}, busy_o, (m_owner >= 0) || m_dead);
        check({tag, "_err"}, err_o, m_dead);
        check({tag, "_cnt"}, cnt_o, m_cnt);
    endtask

    typedef struct {
        logic [N-1:0]  v;
        logic          busy, ack, done;
        logic          req;
        logic [7:0]    idx;
        logic [N-1:0]  ack_o, cmp_o;
        logic [CW-1:0] cnt;
        logic          bsy;
    } vec_t;

    vec_t tbl[19];

    initial begin
        //            v       bsy   ack   done  | req   idx    ack_o   cmp_o   cnt   busy
        tbl[0]  = '{3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 3'b000, 3'b000, 4'd0, 1'b1};
        tbl[1]  = '{3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 3'b000, 3'b000, 4'd0, 1'b1};
        tbl[2]  = '{3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'b010, 3'b000, 4'd0, 1'b1};
        tbl[3]  = '{3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'b000, 3'b000, 4'd0, 1'b1};
        tbl[4]  = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3'b000, 3'b010, 4'd1, 1'b0};
        tbl[5]  = '{3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 3'b000, 3'b000, 4'd1, 1'b1};
        tbl[6]  = '{3'b011, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 3'b001, 3'b000, 4'd1, 1'b1};
        tbl[7]  = '{3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3'b000, 3'b001, 4'd2, 1'b0};
        tbl[8]  = '{3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 3'b000, 3'b000, 4'd2, 1'b0};
        tbl[9]  = '{3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 3'b000, 3'b000, 4'd2, 1'b1};
        tbl[10] = '{3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'b000, 3'b000, 4'd2, 1'b0};
        tbl[11] = '{3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 3'b000, 3'b000, 4'd2, 1'b1};
        tbl[12] = '{3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 3'b000, 3'b000, 4'd2, 1'b1};
        tbl[13] = '{3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'b010, 3'b000, 4'd2, 1'b1};
        tbl[14] = '{3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3'b000, 3'b010, 4'd3, 1'b0};
        tbl[15] = '{3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 3'b000, 3'b000, 4'd3, 1'b1};
        tbl[16] = '{3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'b100, 3'b000, 4'd3, 1'b1};
        tbl[17] = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3'b000, 3'b100, 4'd4, 1'b0};
        tbl[18] = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'b000, 3'b000, 4'd4, 1'b0};

        // Reset state
        model_reset();
        @(negedge clk);
        check("rst_req", req_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        check("rst_cnt", cnt_o, 0);
        check("rst_ack", ack_o, 0);
        check("rst_cmp", cmp_o, 0);
        check("rst_idx", idx_o, 0);
        do_reset();

        // Vector table: grant, ack, complete, rr pointer, hold-off, withdrawal
        for (int i = 0; i < 19; i++) begin
            valid = tbl[i].v; tx_busy = tbl[i].busy; rack = tbl[i].ack; rdone = tbl[i].done;
            tick();
            check($sformatf("vec%0d_req", i), req_o, tbl[i].req);
            if (tbl[i].req) check($sformatf("vec%0d_idx", i), idx_o, tbl[i].idx);
            check($sformatf("vec%0d_ack", i), ack_o, tbl[i].ack_o);
            check($sformatf("vec%0d_cmp", i), cmp_o, tbl[i].cmp_o);
            check($sformatf("vec%0d_cnt", i), cnt_o, tbl[i].cnt);
            check($sformatf("vec%0d_busy", i), busy_o, tbl[i].bsy);
            check($sformatf("vec%0d_err", i), err_o, 0);
        end

        // Round robin with all slots held, plus counter saturation
        do_reset();
        valid = 3'b111;
        for (int r = 0; r < 18; r++) begin
            int w;
            w = 0;
            rack = 1'b0; rdone = 1'b0;
            while (!req_o && w < 5) begin
                tick();
                w++;
            end
            if (!req_o) begin
                check($sformatf("rr%0d_req_timeout", r), req_o, 1);
                break;
            end
            check($sformatf("rr%0d_idx", r), idx_o, r % N);
            rack = 1'b1;
            tick();
            rack = 1'b0;
            rdone = 1'b1;
            tick();
            rdone = 1'b0;
            check($sformatf("rr%0d_cmp", r), cmp_o, 1 << (r % N));
            check($sformatf("rr%0d_cnt", r), cnt_o, (r + 1 < CNT_MAX) ? r + 1 : CNT_MAX);
        end

        // Hold-off while the transmitter is busy
        do_reset();
        valid = 3'b001;
        tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold%0d_req", i), req_o, 0);
        end
        tx_busy = 1'b0;
        tick();
        check("hold_release_req", req_o, 1);
        check("hold_release_idx", idx_o, 0);

        // Timeout: accepted replay never finishes
        do_reset();
        valid = 3'b001;
        tick();
        check("to_req", req_o, 1);
        rack = 1'b1;
        tick();
        rack = 1'b0;
        for (int i = 1; i < TO; i++) begin
            tick();
            check($sformatf("to_stream%0d_err", i), err_o, 0);
        end
        tick();
        check("to_err_set", err_o, 1);
        check("to_busy", busy_o, 1);
        valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("to_dead%0d_req", i), req_o, 0);
            check($sformatf("to_dead%0d_err", i), err_o, 1);
            check($sformatf("to_dead%0d_ack", i), ack_o, 0);
        end

        // Asynchronous reset in the middle of a replay
        do_reset();
        valid = 3'b001;
        tick();
        rack = 1'b1;
        tick();
        rack = 1'b0;
        rdone = 1'b1;
        tick();
        rdone = 1'b0;
        check("ar_cnt_before", cnt_o, 1);
        tick();
        rack = 1'b1;
        tick();
        rack = 1'b0;
        tick();
        check("ar_busy_before", busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_busy", busy_o, 0);
        check("ar_req", req_o, 0);
        check("ar_err", err_o, 0);
        check("ar_cnt", cnt_o, 0);
        check("ar_ack", ack_o, 0);
        check("ar_cmp", cmp_o, 0);
        model_reset();
        valid = 3'b000;
        tick();
        check("ar_cmp_after_edge", cmp_o, 0);
        rst_n = 1'b1;
        valid = 3'b011;
        tick();
        check("ar_regrant_req", req_o, 1);
        check("ar_regrant_idx", idx_o, 0);

        // Random traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) valid = N'($urandom);
            tx_busy = ($urandom_range(3) == 0);
            rack    = ($urandom_range(9) < 4);
            rdone   = ($urandom_range(9) < 3);
            tick();
            check_model($sformatf("rnd%0d", c));
            if (m_dead && $urandom_range(7) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
